// File: rtl/blink_period_meter_pkg.sv
// Shared definitions for the blinker / blink period meter pair.
package blink_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_e;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int clogb2(input longint v);
    int w;
    w = 1;
    for (int i = 0; i < 63; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // Expected interval in clock cycles.
  function automatic longint expected_count(input longint freq_mhz,
                                            input longint interval_ms,
                                            input longint time_scale);
    return freq_mhz * interval_ms * time_scale;
  endfunction

endpackage

// File: rtl/blink_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous toggling input and emits a registered
// one-cycle pulse on either transition.
module sync_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, hist_q, edge_q;

  // Two-flop synchronizer, history flop and registered transition detect.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      edge_q  <= sync2_q ^ hist_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/blink_period_meter.sv
// Measures the interval between toggles of an asynchronous input, checks it
// against the expected blink interval and reports lock / timeout status.
module blink_period_meter
  import blink_period_meter_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 250,
  parameter int INTERVAL_MSEC  = 500,
  parameter int TIME_SCALE     = 1000,
  parameter int TOL_SHIFT      = 4,
  parameter int LOCK_COUNT     = 3,
  localparam longint EXPECTED_COUNT = expected_count(CLOCK_FREQ_MHZ, INTERVAL_MSEC, TIME_SCALE),
  localparam longint TIMEOUT_COUNT  = 2 * EXPECTED_COUNT,
  localparam int     COUNT_WIDTH    = clogb2(TIMEOUT_COUNT)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   blink_i,
  output logic                   period_valid_o,
  output logic [COUNT_WIDTH-1:0] period_count_o,
  output logic                   in_range_o,
  output logic                   locked_o,
  output logic                   timeout_o
);

  localparam longint TOL    = EXPECTED_COUNT >> TOL_SHIFT;
  localparam int     LOCK_W = clogb2(LOCK_COUNT);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT_COUNT);
  localparam logic [COUNT_WIDTH-1:0] LO_C      = COUNT_WIDTH'(EXPECTED_COUNT - TOL);
  localparam logic [COUNT_WIDTH-1:0] HI_C      = COUNT_WIDTH'(EXPECTED_COUNT + TOL);
  localparam logic [LOCK_W-1:0]      LOCK_C    = LOCK_W'(LOCK_COUNT);

  logic                   edge_s;
  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                   in_rng;
  logic                   valid_q, in_range_q, locked_q, timeout_q;
  logic [COUNT_WIDTH-1:0] period_q;

  sync_edge_detect u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (blink_i),
    .edge_o  (edge_s)
  );

  // Next interval count and next lock count for a measurement taken now.
  always_comb begin
    in_rng = (cnt_q >= LO_C) && (cnt_q <= HI_C);
    if (edge_s)               cnt_d = COUNT_WIDTH'(1);
    else if (cnt_q == TIMEOUT_C) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + COUNT_WIDTH'(1);
    lock_cnt_d = lock_cnt_q;
    if (!in_rng)                  lock_cnt_d = '0;
    else if (lock_cnt_q != LOCK_C) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
  end

  // Measurement FSM with registered outputs; an edge always beats a timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      valid_q    <= 1'b0;
      period_q   <= '0;
      in_range_q <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE, MEASURE: begin
          if (edge_s) begin
            state_q <= MEASURE;
            if (state_q == MEASURE) begin
              valid_q    <= 1'b1;
              period_q   <= cnt_q;
              in_range_q <= in_rng;
              lock_cnt_q <= lock_cnt_d;
              locked_q   <= (lock_cnt_d == LOCK_C);
            end
          end else if (cnt_q == TIMEOUT_C) begin
            state_q    <= STALLED;
            timeout_q  <= 1'b1;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
          end
        end
        STALLED: begin
          if (edge_s) begin
            state_q   <= MEASURE;
            timeout_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period_valid_o = valid_q;
  assign period_count_o = period_q;
  assign in_range_o     = in_range_q;
  assign locked_o       = locked_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: timestamp-based reference model checked every
// cycle, plus literal expectations on each reported interval.
module tb_blink_period_meter;

  localparam int EXP   = 20;
  localparam int TOLV  = 5;
  localparam int TMO   = 40;
  localparam int LOCKN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blink = 1'b0;
  logic       period_valid;
  logic [5:0] period_count;
  logic       in_range, locked, timeout;

  blink_period_meter #(
    .CLOCK_FREQ_MHZ(4), .INTERVAL_MSEC(5), .TIME_SCALE(1),
    .TOL_SHIFT(2), .LOCK_COUNT(LOCKN)
  ) dut (
    .clk_i(clk), .reset_i(rst), .blink_i(blink),
    .period_valid_o(period_valid), .period_count_o(period_count),
    .in_range_o(in_range), .locked_o(locked), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timestamps, not states) ----------------
  int  cyc = 0;
  int  last_t;
  int  run;
  bit  m_init = 0, have_ref, seen;
  bit  m_valid, m_ir, m_lk, m_to;
  int  m_cnt;
  int  edge_t[$];

  always @(posedge clk) begin
    bit e;
    cyc = cyc + 1;
    if (rst) begin
      m_init = 1; have_ref = 0; seen = 0; run = 0;
      m_valid = 0; m_ir = 0; m_lk = 0; m_to = 0; m_cnt = 0;
      last_t = cyc + 1;
      edge_t.delete();
    end else if (m_init) begin
      e = (edge_t.size() > 0 && edge_t[0] == cyc);
      if (e) void'(edge_t.pop_front());
      if (blink != seen) begin
        seen = blink;
        edge_t.push_back(cyc + 3);
      end
      m_valid = 0;
      if (e) begin
        if (have_ref) begin
          m_valid = 1;
          m_cnt = (cyc - last_t > TMO) ? TMO : cyc - last_t;
          m_ir = (m_cnt >= EXP - TOLV) && (m_cnt <= EXP + TOLV);
          run = m_ir ? run + 1 : 0;
        end
        have_ref = 1; m_to = 0; last_t = cyc;
      end else if (!m_to && (cyc - last_t >= TMO)) begin
        m_to = 1; have_ref = 0; run = 0;
      end
      m_lk = (run >= LOCKN);
    end
  end

  // ---------------- checking ----------------
  int passed = 0, total = 0;
  int vq_c[$], vq_ir[$], vq_lk[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (m_init) begin
        total++;
        if (period_valid === m_valid && in_range === m_ir && locked === m_lk &&
            timeout === m_to && period_count === 6'(m_cnt))
          passed++;
        else
          $display("FAIL model cyc=%0d: dut v/c/ir/lk/to=%b/%0d/%b/%b/%b required %b/%0d/%b/%b/%b",
                   cyc, period_valid, period_count, in_range, locked, timeout,
                   m_valid, m_cnt, m_ir, m_lk, m_to);
        if (period_valid === 1'b1) begin
          vq_c.push_back(int'(period_count));
          vq_ir.push_back(int'(in_range));
          vq_lk.push_back(int'(locked));
        end
      end
    end
  endtask

  task automatic chk_v(input string nm, input int c, input int ir, input int lk);
    if (vq_c.size() == 0) begin
      total++;
      $display("FAIL %s: got no valid, required count %0d", nm, c);
    end else begin
      chk({nm, " count"}, vq_c.pop_front(), c);
      chk({nm, " in_range"}, vq_ir.pop_front(), ir);
      chk({nm, " locked"}, vq_lk.pop_front(), lk);
    end
  endtask

  task automatic chk_none(input string nm);
    chk({nm, " extra valids"}, vq_c.size(), 0);
    vq_c.delete(); vq_ir.delete(); vq_lk.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, int'(period_valid), 0);
    chk({nm, " count"}, int'(period_count), 0);
    chk({nm, " in_range"}, int'(in_range), 0);
    chk({nm, " locked"}, int'(locked), 0);
    chk({nm, " timeout"}, int'(timeout), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle_after(input int n);
    tick(n);
    blink = ~blink;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    fork monitor(); join_none
    tick(3);
    chk_zero("reset");
    rst = 1'b0;

    // Steady 20-cycle toggling: first edge silent, lock on the third valid.
    toggle_after(2);
    repeat (4) toggle_after(20);
    tick(5);
    chk_v("p1 v1", 20, 1, 0); chk_v("p1 v2", 20, 1, 0);
    chk_v("p1 v3", 20, 1, 1); chk_v("p1 v4", 20, 1, 1);
    chk_none("p1");

    // Tolerance boundaries 15 / 25 in range, 14 / 26 out.
    toggle_after(10);
    toggle_after(25);
    toggle_after(14);
    toggle_after(26);
    tick(5);
    chk_v("p2 15", 15, 1, 1); chk_v("p2 25", 25, 1, 1);
    chk_v("p2 14", 14, 0, 0); chk_v("p2 26", 26, 0, 0);
    chk_none("p2");

    // Lock, then stall into timeout and recover.
    toggle_after(15);
    toggle_after(20);
    toggle_after(20);
    tick(50);
    chk_v("p3 a", 20, 1, 0); chk_v("p3 b", 20, 1, 0); chk_v("p3 c", 20, 1, 1);
    chk_none("p3 pre");
    chk("p3 timeout set", int'(timeout), 1);
    chk("p3 locked cleared", int'(locked), 0);
    toggle_after(1);
    tick(5);
    chk("p3 timeout cleared", int'(timeout), 0);
    chk_none("p3 stall edge");
    toggle_after(15);
    tick(5);
    chk_v("p3 recover", 20, 1, 0);
    chk_none("p3");

    // One-cycle pulse gives a 1-cycle interval.
    toggle_after(15);
    toggle_after(1);
    tick(5);
    chk_v("p4 a", 20, 1, 0); chk_v("p4 pulse", 1, 0, 0);
    chk_none("p4");

    // Lock, then a one-cycle reset.
    toggle_after(15);
    repeat (3) toggle_after(20);
    tick(5);
    chk_v("p5 a", 20, 1, 0); chk_v("p5 b", 20, 1, 0);
    chk_v("p5 c", 20, 1, 1); chk_v("p5 d", 20, 1, 1);
    chk_none("p5 pre");
    chk("p5 locked", int'(locked), 1);
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0;
    chk_zero("p5 reset");
    toggle_after(3);
    toggle_after(20);
    tick(5);
    chk_v("p5 after", 20, 1, 0);
    chk_none("p5");

    // Input held high through reset release.
    tick(1); rst = 1'b1; blink = 1'b1;
    tick(2); rst = 1'b0;
    toggle_after(20);
    tick(5);
    chk_v("p6", 20, 1, 0);
    chk_none("p6");

    // Interval of exactly TIMEOUT_COUNT is measured; longer stalls.
    toggle_after(35);
    tick(5);
    chk_v("p7 40", 40, 0, 0);
    chk("p7 no timeout", int'(timeout), 0);
    tick(40);
    chk("p7 timeout", int'(timeout), 1);
    chk_none("p7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/blink_period_meter.md
# blink_period_meter

Receive-side counterpart of the LED blinker: samples an asynchronous toggling input (a blinker output looped back, or an external heartbeat) and measures the interval between consecutive toggles in CLK cycles. It checks each interval against the expected blink interval within a tolerance, and reports a lock status and a timeout. It sits beside the blinker in the minimum-trigger design as a self-test and heartbeat monitor.

## Interface
- CLOCK_FREQ_MHZ, 250, CLK frequency in MHz
- INTERVAL_MSEC, 500, expected interval between toggles in ms
- TIME_SCALE, 1000, cycles per MHz·ms; benches set 1
- TOL_SHIFT, 4, tolerance = EXPECTED_COUNT >> TOL_SHIFT (must be < EXPECTED_COUNT)
- LOCK_COUNT, 3, consecutive in-range intervals required for lock (≥1)
- Derived: EXPECTED_COUNT = CLOCK_FREQ_MHZ*INTERVAL_MSEC*TIME_SCALE; TIMEOUT_COUNT = 2*EXPECTED_COUNT; COUNT_WIDTH = clogb2(TIMEOUT_COUNT)
- CLK  in  1  single clock
- RESET  in  1  synchronous, active-high reset
- BLINK_IN  in  1  asynchronous toggling input
- PERIOD_VALID  out  1  one-cycle pulse: new measured interval
- PERIOD_COUNT  out  COUNT_WIDTH  last measured interval in cycles, held between pulses
- IN_RANGE  out  1  last interval within tolerance, updated with PERIOD_VALID
- LOCKED  out  1  LOCK_COUNT consecutive in-range intervals, no timeout since
- TIMEOUT  out  1  no toggle for TIMEOUT_COUNT cycles

One clock; reset is synchronous and active-high (CLK, RESET).

## Operation
- BLINK_IN passes through a 2-flop synchronizer, then a history flop; an edge is either transition (sync ≠ history), registered.
- Interval counter cnt: on an edge cycle cnt <= 1; otherwise cnt increments, saturating at TIMEOUT_COUNT. Toggling every N cycles gives PERIOD_COUNT = N.
- States:
  - IDLE (reset): first edge -> MEASURE, no PERIOD_VALID.
  - MEASURE: each edge -> PERIOD_VALID=1, PERIOD_COUNT <= cnt, IN_RANGE updated.
  - STALLED: first edge -> MEASURE, no PERIOD_VALID, TIMEOUT cleared.
  - IDLE or MEASURE with cnt reaching TIMEOUT_COUNT and no edge that cycle -> STALLED; TIMEOUT=1, LOCKED=0, lock counter cleared.
- IN_RANGE = (LO ≤ count ≤ HI), LO = EXPECTED_COUNT−TOL, HI = EXPECTED_COUNT+TOL, as localparams; unsigned COUNT_WIDTH compare.
- Lock counter: in-range valid increments, saturating at LOCK_COUNT; out-of-range valid clears it to 0. LOCKED = (lock counter == LOCK_COUNT), registered, changes in the same cycle as PERIOD_VALID.
- Edge and timeout in the same cycle: the edge wins. No STALLED; the interval is measured normally.
- Reset outputs: PERIOD_VALID, PERIOD_COUNT, IN_RANGE, LOCKED, TIMEOUT all 0; synchronizer and history flops 0; state IDLE; cnt 0.
- RESET mid-operation clears everything next edge. An input held high through reset produces one edge after release, consumed by IDLE.

## Timing
- BLINK_IN change captured at CLK edge k -> PERIOD_VALID high during the cycle after edge k+3. Fixed 3-cycle input latency; the interval count itself is exact.
- PERIOD_VALID is exactly one cycle wide; minimum toggle spacing is 1 cycle (gives PERIOD_COUNT=1).
- TIMEOUT rises in the cycle after cnt reaches TIMEOUT_COUNT; LOCKED falls in the same cycle.
- All outputs are registered; no combinational path from BLINK_IN.

## Structure
- Shared package: the clogb2 function, state enum {IDLE, MEASURE, STALLED}, and the derived-count computation, shared with the blinker.
- Sub-module sync_edge_detect: 2-flop synchronizer, history flop, registered edge pulse. Everything else lives in the top.

## Test plan
Bench parameters: TIME_SCALE=1, CLOCK_FREQ_MHZ=4, INTERVAL_MSEC=5, TOL_SHIFT=2, LOCK_COUNT=3. This gives EXPECTED=20, TOL=5, range 15..25, TIMEOUT=40, COUNT_WIDTH=6.
- Toggle every 20 cycles, 5 edges -> no valid on the 1st edge; valids 2–5 with PERIOD_COUNT=20, IN_RANGE=1; LOCKED rises with the 4th edge's valid.
- Intervals 15, 25, then 14 -> IN_RANGE 1, 1, 0; LOCKED falls on the 14 valid; then 26 -> IN_RANGE=0.
- Lock, then hold input 40 cycles -> TIMEOUT=1, LOCKED=0. Next edge -> no valid, TIMEOUT=0; next 20-cycle interval valid with lock counter 1.
- 1-cycle pulse on BLINK_IN in MEASURE -> two valids, second PERIOD_COUNT=1, IN_RANGE=0.
- RESET for 1 cycle while LOCKED -> all outputs 0 next cycle; the first subsequent edge gives no valid.
- BLINK_IN held 1 through reset release -> one internal edge, no PERIOD_VALID; the next toggle 20 cycles later gives PERIOD_COUNT=20.
